pilot_gain_req: RTL and testbench
=================================

# pilot_gain_req

Pilot-averaging and divide-request stage sitting directly upstream of the receiver's pipelined restoring divider. It averages a block of 2^LOG2_PILOTS pilot amplitudes after each frame start, issues one divide request (REF_LEVEL / mean), and captures the divider's quotient as the channel gain used by the PAM slicer. It owns the whole request/response exchange, including divide-by-zero protection and a response timeout.

## Interface
Parameters:
- SAMPLE_W, 12: unsigned pilot amplitude width; equals the divider's WIDTH_DIVISOR.
- DIV_W, 16: dividend/quotient width; equals the divider's WIDTH_DIVIDEND. The divider latency is DIV_W cycles.
- LOG2_PILOTS, 4: log2 of the number of pilots averaged per frame. Must be at least 1.
- REF_LEVEL, 16'd40960: constant dividend (nominal pilot amplitude scaled by the gain fraction), DIV_W bits.

Ports:
- clk, in, 1: clock.
- arst, in, 1: reset. Asynchronous assert, active-high.
- frame_sof, in, 1: one-cycle frame-start pulse.
- sample_valid, in, 1: sample qualifier.
- sample, in, SAMPLE_W: unsigned pilot amplitude.
- div_en, out, 1: one-cycle divide request to the divider's en.
- div_dividend, out, DIV_W: always REF_LEVEL.
- div_divisor, out, SAMPLE_W: clamped mean, held stable from ISSUE until the block leaves WAIT.
- div_rdy, in, 1: divider output strobe.
- div_result, in, DIV_W: divider quotient. The remainder is not used.
- gain, out, DIV_W: latest captured quotient.
- gain_valid, out, 1: one-cycle pulse when gain updates.
- gain_zero_err, out, 1: set on the gain_valid cycle if the pre-clamp mean was 0; held until the next gain_valid.
- div_timeout, out, 1: one-cycle pulse on response timeout.
- sof_ignored, out, 1: one-cycle pulse when frame_sof arrives in ISSUE or WAIT.

## Operation
State machine IDLE, ACC, ISSUE, WAIT:
- **IDLE**
  - frame_sof → ACC.
  - On entry to ACC, clear the accumulator (width SAMPLE_W+LOG2_PILOTS, cannot overflow) and the sample count.
- **ACC**
  - Each sample_valid adds sample to the accumulator and increments the count.
  - On the 2^LOG2_PILOTS-th valid sample → ISSUE.
  - frame_sof in ACC restarts accumulation. That cycle's sample is discarded even if it is valid.
  - frame_sof has priority over sample_valid.
- **ISSUE** (one cycle)
  - Drive div_en=1. Register the divisor. Go to WAIT.
- **WAIT**
  - div_rdy → gain<=div_result, gain_valid pulse, gain_zero_err updated, go to IDLE.
  - If no div_rdy arrives within DIV_W+4 cycles after div_en → div_timeout pulse, gain unchanged, go to IDLE.
- Mean = accumulator >> LOG2_PILOTS (truncation; see Configuration). Divisor = mean, or 1 if mean==0.
- div_rdy outside WAIT is ignored.
- frame_sof in ISSUE or WAIT produces a sof_ignored pulse and nothing else.

## Timing
- Reset values:
  - State: IDLE.
  - div_en, gain_valid, div_timeout, sof_ignored: 0.
  - gain: 0.
  - gain_zero_err: 0.
  - div_divisor: 1.
  - div_dividend: constant REF_LEVEL.
- Last pilot accepted at cycle t (registered) → div_en high in cycle t+1.
- With the divider's DIV_W-cycle latency, div_rdy arrives at t+1+DIV_W. gain and gain_valid are registered one cycle later.
- The timeout counter starts on the div_en cycle. div_timeout asserts on count DIV_W+4 if div_rdy is still absent.
- A simultaneous div_rdy on the timeout cycle counts as a success; no timeout is flagged.
- Back-to-back frames: a new frame_sof is accepted from the IDLE cycle following gain_valid or div_timeout.
- arst mid-operation returns the block to reset values immediately. A divider response still in flight after reset is ignored because the state is IDLE.
- All outputs are registered.

## Configuration
- **PILOT_GAIN_ROUND_EN defined:** mean = min((acc + 2^(LOG2_PILOTS-1)) >> LOG2_PILOTS, 2^SAMPLE_W-1). This is round-half-up with saturation.
- **Undefined:** truncated mean. Zero-clamp and all other behaviour are identical in both cases.

## Test plan
All scenarios use default parameters and a real divider instance as the responder.
1. **Nominal gain.** frame_sof, then 16 samples of 1024 → div_divisor=1024, div_en one cycle after the 16th sample, gain=40, gain_valid 17 cycles after div_en, gain_zero_err=0.
2. **Rounding.** 15 samples of 100 plus one of 108 (sum 1608) → macro undefined: divisor 100, gain 409. Macro defined: divisor 101, gain 405.
3. **Zero pilots.** 16 samples of 0 → divisor 1, gain 40960, gain_zero_err=1. The next nominal frame clears gain_zero_err.
4. **Restart and ignore.**
   - frame_sof after 7 samples → count restarts; a further 16 samples are required before div_en.
   - frame_sof during WAIT → sof_ignored pulse, result unaffected.
5. **Timeout.** Stub divider with div_rdy tied low → div_timeout exactly 20 cycles after div_en, gain keeps its previous value, state returns to IDLE.
6. **Reset mid-operation.** Assert arst during ACC and again during WAIT → outputs go to reset values immediately. The late div_rdy after reset produces no gain_valid.

Source files
------------

// File: rtl/pilot_gain_req_if.sv
// Pilot-gain request bus: pilot samples in, divider request/response, and
// gain results out. The master side is pilot_gain_req; the slave side is
// whatever feeds samples and hosts the divider.
interface pilot_gain_req_if #(
  parameter int SAMPLE_W = 12,
  parameter int DIV_W    = 16
);
  logic                frame_sof;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                div_en;
  logic [DIV_W-1:0]    div_dividend;
  logic [SAMPLE_W-1:0] div_divisor;
  logic                div_rdy;
  logic [DIV_W-1:0]    div_result;
  logic [DIV_W-1:0]    gain;
  logic                gain_valid;
  logic                gain_zero_err;
  logic                div_timeout;
  logic                sof_ignored;

  modport master (
    input  frame_sof, sample_valid, sample, div_rdy, div_result,
    output div_en, div_dividend, div_divisor, gain, gain_valid,
           gain_zero_err, div_timeout, sof_ignored
  );

  modport slave (
    output frame_sof, sample_valid, sample, div_rdy, div_result,
    input  div_en, div_dividend, div_divisor, gain, gain_valid,
           gain_zero_err, div_timeout, sof_ignored
  );
endinterface

// File: rtl/pilot_gain_req.sv
// Pilot averaging and divide-request stage. After each frame start it sums
// 2^LOG2_PILOTS pilot amplitudes, issues one REF_LEVEL / mean request to the
// pipelined divider, and captures the quotient as the slicer gain. A zero
// mean is clamped to 1 and flagged; a missing divider response times out
// DIV_W+4 cycles after the request.
// Optional feature: define PILOT_GAIN_ROUND_EN for a round-half-up,
// saturating mean instead of the default truncated mean.
module pilot_gain_req #(
  parameter int                SAMPLE_W    = 12,
  parameter int                DIV_W       = 16,
  parameter int                LOG2_PILOTS = 4,
  parameter logic [DIV_W-1:0]  REF_LEVEL   = 16'd40960
) (
  input  logic               clk,
  input  logic               arst,
  pilot_gain_req_if.master   bus
);

  localparam int ACC_W    = SAMPLE_W + LOG2_PILOTS;
  localparam int TMO_W    = $clog2(DIV_W + 4);
  // Last WAIT count at which a response is still accepted; the request cycle
  // is count 0, so a timeout lands exactly DIV_W+4 cycles after div_en.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_W + 3);

  typedef enum logic [1:0] {IDLE, ACC, ISSUE, WAIT} state_e;

  state_e                   state_q;
  logic [ACC_W-1:0]         acc_q;
  logic [LOG2_PILOTS-1:0]   cnt_q;
  logic [TMO_W-1:0]         tmo_q;
  logic                     zero_mean_q;
  logic                     div_en_q;
  logic [SAMPLE_W-1:0]      div_divisor_q;
  logic [DIV_W-1:0]         gain_q;
  logic                     gain_valid_q;
  logic                     gain_zero_err_q;
  logic                     div_timeout_q;
  logic                     sof_ignored_q;

  logic [ACC_W-1:0]         acc_d;
  logic [SAMPLE_W-1:0]      mean_d;
  logic                     mean_zero_d;

  // Running sum including the sample on the bus this cycle, so the divisor
  // is ready on the same edge that accepts the last pilot.
  assign acc_d = acc_q + ACC_W'(bus.sample);

`ifdef PILOT_GAIN_ROUND_EN
  localparam logic [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (LOG2_PILOTS - 1);
  logic [ACC_W:0]           acc_rnd_d;
  logic [SAMPLE_W:0]        mean_wide_d;
  logic [LOG2_PILOTS-1:0]   unused_frac_bits;
  assign acc_rnd_d        = {1'b0, acc_d} + RND_HALF;
  assign mean_wide_d      = acc_rnd_d[ACC_W:LOG2_PILOTS];
  assign unused_frac_bits = acc_rnd_d[LOG2_PILOTS-1:0];
  assign mean_d           = mean_wide_d[SAMPLE_W] ? '1 : mean_wide_d[SAMPLE_W-1:0];
`else
  logic [LOG2_PILOTS-1:0]   unused_frac_bits;
  assign mean_d           = acc_d[ACC_W-1:LOG2_PILOTS];
  assign unused_frac_bits = acc_d[LOG2_PILOTS-1:0];
`endif

  assign mean_zero_d = (mean_d == '0);

  // Control FSM with all outputs registered; pulses default low every cycle.
  // NOTE: every register here uses <= so all state updates on one edge see
  // the same pre-edge values; a blocking = would leak new values into later
  // statements and create order-dependent behaviour.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      // NOTE: the accumulator and counters are reset too even though ACC
      // entry clears them, so no register ever powers up as X.
      state_q         <= IDLE;
      acc_q           <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      zero_mean_q     <= 1'b0;
      div_en_q        <= 1'b0;
      div_divisor_q   <= SAMPLE_W'(1);
      gain_q          <= '0;
      gain_valid_q    <= 1'b0;
      gain_zero_err_q <= 1'b0;
      div_timeout_q   <= 1'b0;
      sof_ignored_q   <= 1'b0;
    end else begin
      div_en_q      <= 1'b0;
      gain_valid_q  <= 1'b0;
      div_timeout_q <= 1'b0;
      sof_ignored_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.frame_sof) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ACC: begin
          // A frame start wins over a coincident sample and restarts the sum.
          if (bus.frame_sof) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (bus.sample_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_q       <= ISSUE;
              div_en_q      <= 1'b1;
              div_divisor_q <= mean_zero_d ? SAMPLE_W'(1) : mean_d;
              zero_mean_q   <= mean_zero_d;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          tmo_q   <= TMO_W'(1);
          if (bus.frame_sof) sof_ignored_q <= 1'b1;
        end
        WAIT: begin
          if (bus.frame_sof) sof_ignored_q <= 1'b1;
          // A response on the final allowed cycle still counts as success.
          if (bus.div_rdy) begin
            state_q         <= IDLE;
            gain_q          <= bus.div_result;
            gain_valid_q    <= 1'b1;
            gain_zero_err_q <= zero_mean_q;
          end else if (tmo_q == TMO_LAST) begin
            state_q       <= IDLE;
            div_timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.div_en        = div_en_q;
  assign bus.div_dividend  = REF_LEVEL;
  assign bus.div_divisor   = div_divisor_q;
  assign bus.gain          = gain_q;
  assign bus.gain_valid    = gain_valid_q;
  assign bus.gain_zero_err = gain_zero_err_q;
  assign bus.div_timeout   = div_timeout_q;
  assign bus.sof_ignored   = sof_ignored_q;

endmodule

// File: tb/tb_pilot_gain_req.sv
// Scoreboard bench for pilot_gain_req. The stimulus process pushes the
// hand-computed divisor, request cycle, gain and flags for each frame; a
// negedge monitor pops and compares whenever the DUT strobes an output.
// A behavioural DIV_W-stage divider pipeline answers the requests.
module tb_pilot_gain_req;
  localparam int SAMPLE_W = 12;
  localparam int DIV_W    = 16;

  typedef enum int {M_GAIN, M_TMO, M_RESET} mode_e;
  typedef struct packed {
    logic [DIV_W-1:0] g;
    logic             z;
  } gexp_t;

  logic clk = 1'b0;
  logic arst;
  logic stub = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   en_cyc = 0;
  int   exp_tmo_n = 0;
  logic [DIV_W-1:0] gain_model = '0;

  gexp_t               exp_gain_q[$];
  logic [SAMPLE_W-1:0] exp_div_q[$];
  int                  exp_en_q[$];
  int                  exp_ign_q[$];

  pilot_gain_req_if #(.SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W)) bus ();

  pilot_gain_req dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider responder: DIV_W-cycle pipeline, not cleared by arst.
  logic [DIV_W-1:0] pv = '0;
  logic [DIV_W-1:0] pq [DIV_W];
  always @(posedge clk) begin
    pv <= {pv[DIV_W-2:0], bus.div_en};
    pq[0] <= (bus.div_divisor == '0) ? '1 : bus.div_dividend / DIV_W'(bus.div_divisor);
    for (int i = 1; i < DIV_W; i++) pq[i] <= pq[i-1];
  end
  assign bus.div_rdy    = pv[DIV_W-1] && !stub;
  assign bus.div_result = pq[DIV_W-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: strobe seen with no expectation pending (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every DUT strobe against the scoreboard.
  always @(negedge clk) begin
    if (!arst) begin
      if (bus.div_en) begin
        if (exp_en_q.size() == 0) fail_event("div_en_unexpected");
        else begin
          check("div_en_cycle", cyc, exp_en_q.pop_front());
          check("div_divisor", 32'(bus.div_divisor), 32'(exp_div_q.pop_front()));
          check("div_dividend", 32'(bus.div_dividend), 40960);
        end
        en_cyc = cyc;
      end
      if (bus.gain_valid) begin
        if (exp_gain_q.size() == 0) fail_event("gain_valid_unexpected");
        else begin
          gexp_t e;
          e = exp_gain_q.pop_front();
          check("gain", 32'(bus.gain), 32'(e.g));
          check("gain_zero_err", 32'(bus.gain_zero_err), 32'(e.z));
          check("gain_latency", cyc - en_cyc, 17);
          gain_model = e.g;
        end
        done_cnt++;
      end
      if (bus.div_timeout) begin
        if (exp_tmo_n == 0) fail_event("div_timeout_unexpected");
        else begin
          exp_tmo_n--;
          check("timeout_latency", cyc - en_cyc, 20);
          check("gain_kept_on_timeout", 32'(bus.gain), 32'(gain_model));
        end
        done_cnt++;
      end
      if (bus.sof_ignored) begin
        if (exp_ign_q.size() == 0) fail_event("sof_ignored_unexpected");
        else check("sof_ignored_cycle", cyc, exp_ign_q.pop_front());
      end
    end
  end

  task automatic cyc_drive(input logic sof, input logic val, input logic [SAMPLE_W-1:0] s);
    @(negedge clk);
    bus.frame_sof    = sof;
    bus.sample_valid = val;
    bus.sample       = s;
  endtask

  task automatic check_reset_vals();
    check("rst_div_en", 32'(bus.div_en), 0);
    check("rst_gain_valid", 32'(bus.gain_valid), 0);
    check("rst_div_timeout", 32'(bus.div_timeout), 0);
    check("rst_sof_ignored", 32'(bus.sof_ignored), 0);
    check("rst_gain", 32'(bus.gain), 0);
    check("rst_gain_zero_err", 32'(bus.gain_zero_err), 0);
    check("rst_div_divisor", 32'(bus.div_divisor), 1);
    check("rst_div_dividend", 32'(bus.div_dividend), 40960);
  endtask

  // Asynchronous reset mid-cycle; values are checked before the next edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2 arst = 1'b1;
    #1 check_reset_vals();
    gain_model = '0;
    @(negedge clk);
    arst = 1'b0;
  endtask

  // One frame: sof (with a valid sample that must be discarded), 15 samples
  // of val and one of last, then wait for the response or timeout.
  task automatic run_frame(input logic [SAMPLE_W-1:0] val, input logic [SAMPLE_W-1:0] last,
                           input logic [SAMPLE_W-1:0] exp_div, input logic [DIV_W-1:0] exp_g,
                           input logic exp_z, input mode_e mode, input bit sof_wait);
    int start;
    int k;
    start = done_cnt;
    stub  = (mode == M_TMO);
    exp_div_q.push_back(exp_div);
    if (mode == M_TMO) exp_tmo_n++;
    else if (mode == M_GAIN) exp_gain_q.push_back('{g: exp_g, z: exp_z});
    cyc_drive(1'b1, 1'b1, '1);
    for (int i = 0; i < 15; i++) cyc_drive(1'b0, 1'b1, val);
    cyc_drive(1'b0, 1'b1, last);
    exp_en_q.push_back(cyc + 1);
    cyc_drive(1'b0, 1'b0, '0);
    if (sof_wait) begin
      repeat (3) cyc_drive(1'b0, 1'b0, '0);
      cyc_drive(1'b1, 1'b0, '0);
      exp_ign_q.push_back(cyc + 1);
      cyc_drive(1'b0, 1'b0, '0);
    end
    if (mode == M_RESET) begin
      repeat (5) @(negedge clk);
      pulse_reset();
      repeat (25) @(negedge clk);
      check("no_gain_after_reset", done_cnt, start);
    end else begin
      k = 0;
      while (done_cnt == start && k < 60) begin
        @(negedge clk);
        k++;
      end
      check("frame_completed", 32'(done_cnt != start), 1);
    end
    repeat (2) @(negedge clk);
    stub = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    arst = 1'b1;
    bus.frame_sof    = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    #3 check_reset_vals();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal: mean 1024 -> 40960/1024 = 40.
    run_frame(12'd1024, 12'd1024, 12'd1024, 16'd40, 1'b0, M_GAIN, 1'b0);
    // Sum 1608: truncated 100 -> 409; rounded 101 -> 405.
`ifdef PILOT_GAIN_ROUND_EN
    run_frame(12'd100, 12'd108, 12'd101, 16'd405, 1'b0, M_GAIN, 1'b0);
`else
    run_frame(12'd100, 12'd108, 12'd100, 16'd409, 1'b0, M_GAIN, 1'b0);
`endif
    // Zero pilots: clamped divisor 1, full-scale gain, error flagged.
    run_frame(12'd0, 12'd0, 12'd1, 16'd40960, 1'b1, M_GAIN, 1'b0);
    // Timeout: no response; gain and zero flag keep their values.
    run_frame(12'd1024, 12'd1024, 12'd1024, 16'd0, 1'b0, M_TMO, 1'b0);
    check("gain_after_timeout", 32'(bus.gain), 40960);
    check("zero_err_held_after_timeout", 32'(bus.gain_zero_err), 1);
    // Nominal frame clears the zero flag.
    run_frame(12'd1024, 12'd1024, 12'd1024, 16'd40, 1'b0, M_GAIN, 1'b0);
    // Sum 15: truncated mean 0 (clamped, flagged); rounded mean 1.
`ifdef PILOT_GAIN_ROUND_EN
    run_frame(12'd0, 12'd15, 12'd1, 16'd40960, 1'b0, M_GAIN, 1'b0);
`else
    run_frame(12'd0, 12'd15, 12'd1, 16'd40960, 1'b1, M_GAIN, 1'b0);
`endif
    // Full-scale pilots: mean 4095 -> 10.
    run_frame(12'd4095, 12'd4095, 12'd4095, 16'd10, 1'b0, M_GAIN, 1'b0);
    // Restart after 7 samples, then sof during WAIT: mean 2000 -> 20.
    cyc_drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) cyc_drive(1'b0, 1'b1, 12'd500);
    run_frame(12'd2000, 12'd2000, 12'd2000, 16'd20, 1'b0, M_GAIN, 1'b1);
    // Mean 7 -> 5851.
    run_frame(12'd7, 12'd7, 12'd7, 16'd5851, 1'b0, M_GAIN, 1'b0);
    // Reset during ACC, then a normal frame.
    cyc_drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc_drive(1'b0, 1'b1, 12'd300);
    cyc_drive(1'b0, 1'b0, '0);
    pulse_reset();
    repeat (2) @(negedge clk);
    run_frame(12'd1024, 12'd1024, 12'd1024, 16'd40, 1'b0, M_GAIN, 1'b0);
    // Reset during WAIT: the late divider response must be ignored.
    run_frame(12'd512, 12'd512, 12'd512, 16'd0, 1'b0, M_RESET, 1'b0);
    check("gain_zero_after_wait_reset", 32'(bus.gain), 0);
    // Recovery: mean 512 -> 80.
    run_frame(12'd512, 12'd512, 12'd512, 16'd80, 1'b0, M_GAIN, 1'b0);

    check("pending_expectations",
          exp_gain_q.size() + exp_en_q.size() + exp_ign_q.size() + exp_tmo_n, 0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
